wrr_arbiter: RTL and testbench

WRR_ARBITER -- requirements
Module: wrr_arbiter

---
 rtl/wrr_arbiter.sv | 90 +++++++++
 tb/tb_wrr_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: each grant is a burst of up to weight[i]
// cycles, and the next requester in rotate order is granted with no bubble.
module wrr_arbiter #(
  parameter int N  = 4,
  parameter int WW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic [N*WW-1:0]      weight,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_last
);

  localparam int IW = $clog2(N);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e         state_q;
  logic [N-1:0]   grant_q;
  logic [IW-1:0]  idx_q;
  logic [IW-1:0]  ptr_q;
  logic [WW-1:0]  cnt_q;

  logic           pick_found_s;
  logic [IW-1:0]  pick_idx_s;
  logic [WW-1:0]  wfield_s;
  logic [WW-1:0]  cnt_load_s;
  logic [IW-1:0]  ptr_next_s;
  logic           keep_s;
  logic           issue_s;

  // First requester in rotate order from ptr_q; walking backwards lets the
  // earliest position in the order overwrite later ones.
  always_comb begin
    int j;
    j            = 0;
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j            = int'(ptr_q) + k;
      j            = (j >= N) ? j - N : j;
      pick_found_s = pick_found_s | req[j];
      pick_idx_s   = req[j] ? IW'(j) : pick_idx_s;
    end
  end

  // Burst length of the candidate, with a zero weight meaning one cycle.
  always_comb begin
    wfield_s   = weight[int'(pick_idx_s)*WW +: WW];
    cnt_load_s = (wfield_s == '0) ? '0 : wfield_s - 1'b1;
    ptr_next_s = (pick_idx_s == IW'(N - 1)) ? '0 : pick_idx_s + 1'b1;
    keep_s     = (state_q == ST_GRANT) && req[idx_q] && (cnt_q != '0);
    issue_s    = en && pick_found_s;
  end

  // Grant FSM: hold while credit remains, otherwise hand over at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else if (keep_s) begin
      cnt_q <= cnt_q - 1'b1;
    end else if (issue_s) begin
      state_q <= ST_GRANT;
      grant_q <= {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
      idx_q   <= pick_idx_s;
      ptr_q   <= ptr_next_s;
      cnt_q   <= cnt_load_s;
    end else begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end
  end

  assign grant      = grant_q;
  assign grant_idx  = idx_q;
  assign grant_last = (state_q == ST_GRANT) && (cnt_q == '0);

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios with literal expectations plus a
// randomized run checked every cycle against an integer burst model.
module tb_wrr_arbiter;
  localparam int N  = 4;
  localparam int WW = 4;

  logic            clk    = 1'b0;
  logic            rst_n  = 1'b0;
  logic            en     = 1'b0;
  logic [N-1:0]    req    = '0;
  logic [N*WW-1:0] weight = '0;
  logic [N-1:0]    grant;
  logic [1:0]      grant_idx;
  logic            grant_last;

  int total = 0;
  int bad   = 0;

  // Model: who holds the grant, how many credited cycles remain after this
  // one, and where the next search starts.
  bit m_on   = 1'b0;
  int m_g    = 0;
  int m_left = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  wrr_arbiter #(.N(N), .WW(WW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .weight     (weight),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_last (grant_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_on = 1'b0; m_g = 0; m_left = 0; m_ptr = 0;
    end else if (m_on && req[m_g] && m_left > 0) begin
      m_left = m_left - 1;
    end else begin
      int pick;
      int w;
      pick = -1;
      for (int k = 0; k < N; k++)
        if (pick < 0 && req[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
      if (en && pick >= 0) begin
        w      = int'(weight[pick*WW +: WW]);
        m_on   = 1'b1;
        m_g    = pick;
        m_ptr  = (pick + 1) % N;
        m_left = (w == 0) ? 0 : w - 1;
      end else begin
        m_on = 1'b0; m_g = 0; m_left = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] eg;
    eg = m_on ? (4'b0001 << m_g) : 4'b0000;
    chk("model_grant", 32'(grant), 32'(eg));
    chk("model_idx", 32'(grant_idx), m_on ? 32'(m_g) : 32'd0);
    chk("model_last", 32'(grant_last), 32'(m_on && m_left == 0));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] s2 [9];
    s2 = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};

    // Reset mid-burst clears outputs at once; arbitration restarts at 0.
    do_reset();
    en = 1'b1; req = 4'b1111; weight = 16'h4444;
    tick(); tick();
    chk("s1_pre_grant", 32'(grant), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("s1_rst_grant", 32'(grant), 32'h0);
    chk("s1_rst_idx", 32'(grant_idx), 32'h0);
    chk("s1_rst_last", 32'(grant_last), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("s1_first_grant", 32'(grant), 32'h1);

    // All weights 2: each requester held two cycles, no gaps.
    do_reset();
    en = 1'b1; req = 4'b1111; weight = 16'h2222;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("s2_grant", 32'(grant), 32'(s2[i]));
      chk("s2_last", 32'(grant_last), 32'(i % 2 == 1));
    end

    // weight0=3, weight1=1 with two requesters.
    do_reset();
    en = 1'b1; req = 4'b0011; weight = 16'h0013;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("s3_grant", 32'(grant), (i % 4 == 3) ? 32'h2 : 32'h1);
      chk("s3_last", 32'(grant_last), 32'(i % 4 >= 2));
    end

    // Requester 0 drops its request early; requester 2 follows immediately.
    do_reset();
    en = 1'b1; req = 4'b0101; weight = 16'h0104;
    tick();
    chk("s4_grant0", 32'(grant), 32'h1);
    chk("s4_last0", 32'(grant_last), 32'h0);
    req = 4'b0100;
    tick();
    chk("s4_grant2", 32'(grant), 32'h4);
    chk("s4_idx2", 32'(grant_idx), 32'h2);

    // Sole requester with zero weight is re-granted every cycle.
    do_reset();
    en = 1'b1; req = 4'b0100; weight = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s5_grant", 32'(grant), 32'h4);
      chk("s5_last", 32'(grant_last), 32'h1);
    end

    // en dropped during requester 1's weight-3 burst.
    do_reset();
    en = 1'b1; req = 4'b1111; weight = 16'h1131;
    tick();
    chk("s6_g0", 32'(grant), 32'h1);
    tick();
    chk("s6_g1_first", 32'(grant), 32'h2);
    en = 1'b0;
    tick();
    chk("s6_g1_mid", 32'(grant), 32'h2);
    tick();
    chk("s6_g1_end", 32'(grant), 32'h2);
    chk("s6_g1_last", 32'(grant_last), 32'h1);
    tick();
    chk("s6_idle", 32'(grant), 32'h0);
    tick();
    chk("s6_idle2", 32'(grant), 32'h0);
    en = 1'b1;
    tick();
    chk("s6_resume", 32'(grant), 32'h4);

    // Randomized traffic, including occasional resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req    = 4'($urandom);
      weight = 16'($urandom);
      en     = ($urandom_range(0, 7) != 0);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
